// File: rtl/vga_image_fetch.sv
// Pixel-fetch stage behind the 640x480 timing controller: places a stored image window on screen,
// reads it from a double-buffered BRAM, and keeps sync/blank aligned with the returned RGB.
module vga_image_fetch #(
    parameter int          IMG_W       = 128,
    parameter int          IMG_H       = 128,
    parameter int          X0          = 256,
    parameter int          Y0          = 176,
    parameter int          SCALE_SHIFT = 0,
    parameter int          MEM_LAT     = 1,
    parameter int          ADDR_W      = 15,
    parameter int          VLINES      = 480,
    parameter logic [7:0]  BG_COLOR    = 8'h00
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [10:0]       hcounter,
    input  logic [10:0]       vcounter,
    input  logic              HS_in,
    input  logic              VS_in,
    input  logic              blank_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [7:0]        mem_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              wr_bank,
    output logic [7:0]        rgb,
    output logic              HS_out,
    output logic              VS_out,
    output logic              blank_out
);

    localparam int                L         = MEM_LAT + 2;
    localparam int                COL_W     = $clog2(IMG_W);
    localparam logic [11:0]       X_LO      = 12'(X0);
    localparam logic [11:0]       X_HI      = 12'(X0 + (IMG_W << SCALE_SHIFT));
    localparam logic [11:0]       Y_LO      = 12'(Y0);
    localparam logic [11:0]       Y_HI      = 12'(Y0 + (IMG_H << SCALE_SHIFT));
    localparam logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(IMG_W * IMG_H);
    localparam logic [10:0]       VLINE_C   = 11'(VLINES);

    logic [11:0]       h_s;
    logic [11:0]       v_s;
    logic [11:0]       col_s;
    logic [11:0]       row_s;
    logic              in_win_s;
    logic              swap_now_s;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_LAT:0]  win_sr_q;
    logic [L-1:0]      hs_sr_q;
    logic [L-1:0]      vs_sr_q;
    logic [L-1:0]      blank_sr_q;
    logic [7:0]        rgb_q, rgb_d;
    logic              disp_bank_q;
    logic              swap_ack_q;
    logic              swap_pend_q, swap_pend_d;

    assign h_s   = {1'b0, hcounter};
    assign v_s   = {1'b0, vcounter};
    assign col_s = (h_s - X_LO) >> SCALE_SHIFT;
    assign row_s = (v_s - Y_LO) >> SCALE_SHIFT;

    // Window test and bank-swap decision on the incoming counters
    always_comb begin
        in_win_s   = 1'b0;
        swap_now_s = 1'b0;
        if ((h_s >= X_LO) && (h_s < X_HI) && (v_s >= Y_LO) && (v_s < Y_HI)) begin
            in_win_s = 1'b1;
        end else begin
            in_win_s = 1'b0;
        end
        // A request latched earlier in the frame is honoured at the first invisible line
        if ((hcounter == 11'd0) && (vcounter == VLINE_C) && (swap_req || swap_pend_q)) begin
            swap_now_s = 1'b1;
        end else begin
            swap_now_s = 1'b0;
        end
    end

    // Next-state values for address, pending swap and output colour
    always_comb begin
        mem_addr_d  = mem_addr_q;
        swap_pend_d = swap_pend_q;
        rgb_d       = BG_COLOR;
        if (in_win_s) begin
            mem_addr_d = (disp_bank_q ? BANK_SIZE : {ADDR_W{1'b0}})
                       + (ADDR_W'(row_s) << COL_W)
                       + ADDR_W'(col_s);
        end else begin
            mem_addr_d = mem_addr_q;
        end
        if (swap_now_s) begin
            swap_pend_d = 1'b0;
        end else begin
            swap_pend_d = swap_pend_q | swap_req;
        end
        // Blank and window flag are taken at the stage where mem_data is valid
        if (blank_sr_q[L-2]) begin
            rgb_d = 8'h00;
        end else if (win_sr_q[MEM_LAT]) begin
            rgb_d = mem_data;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // Address stage, memory-aligned delay lines, output register and bank state
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= {ADDR_W{1'b0}};
            win_sr_q    <= {(MEM_LAT+1){1'b0}};
            hs_sr_q     <= {L{1'b1}};
            vs_sr_q     <= {L{1'b1}};
            blank_sr_q  <= {L{1'b1}};
            rgb_q       <= 8'h00;
            disp_bank_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            win_sr_q    <= {win_sr_q[MEM_LAT-1:0], in_win_s};
            hs_sr_q     <= {hs_sr_q[L-2:0], HS_in};
            vs_sr_q     <= {vs_sr_q[L-2:0], VS_in};
            blank_sr_q  <= {blank_sr_q[L-2:0], blank_in};
            rgb_q       <= rgb_d;
            disp_bank_q <= disp_bank_q ^ swap_now_s;
            swap_ack_q  <= swap_now_s;
            swap_pend_q <= swap_pend_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_en    = win_sr_q[0];
    assign rgb       = rgb_q;
    assign HS_out    = hs_sr_q[L-1];
    assign VS_out    = vs_sr_q[L-1];
    assign blank_out = blank_sr_q[L-1];
    assign swap_ack  = swap_ack_q;
    assign wr_bank   = ~disp_bank_q;

endmodule

// File: tb/tb_vga_image_fetch.sv
// Directed bench for vga_image_fetch: vector table for the window/pipeline path plus
// hand-written sequences for latency, bank swap, scaling and mid-line reset.
module tb_vga_image_fetch;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcounter = 11'd0;
    logic [10:0] vcounter = 11'd0;
    logic        HS_in = 1'b1, VS_in = 1'b1, blank_in = 1'b1;
    logic        swap_req = 1'b0;
    logic [14:0] mem_addr;
    logic        mem_en;
    logic [7:0]  mem_q = 8'h00;
    logic        swap_ack, wr_bank;
    logic [7:0]  rgb;
    logic        HS_out, VS_out, blank_out;

    logic [14:0] mem_addr2;
    logic        mem_en2, swap_ack2, wr_bank2, HS_out2, VS_out2, blank_out2;
    logic [7:0]  rgb2;
    logic [7:0]  mem_data2 = 8'h00;

    logic [7:0]  mem [0:32767];
    int          errors = 0;
    int          checks = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_image_fetch #(.BG_COLOR(8'h25)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
        .HS_in(HS_in), .VS_in(VS_in), .blank_in(blank_in),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_q),
        .swap_req(swap_req), .swap_ack(swap_ack), .wr_bank(wr_bank),
        .rgb(rgb), .HS_out(HS_out), .VS_out(VS_out), .blank_out(blank_out)
    );

    vga_image_fetch #(.SCALE_SHIFT(1), .X0(64), .Y0(112)) dut_s (
        .pixel_clk(pixel_clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
        .HS_in(HS_in), .VS_in(VS_in), .blank_in(blank_in),
        .mem_addr(mem_addr2), .mem_en(mem_en2), .mem_data(mem_data2),
        .swap_req(1'b0), .swap_ack(swap_ack2), .wr_bank(wr_bank2),
        .rgb(rgb2), .HS_out(HS_out2), .VS_out(VS_out2), .blank_out(blank_out2)
    );

    // One-cycle-latency BRAM model
    always @(posedge pixel_clk) begin
        if (mem_en) mem_q <= mem[mem_addr];
    end

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        blk;
        logic        hs;
        logic        vs;
        logic        en;
        logic [14:0] addr;
        logic [7:0]  rgb;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v);
        hcounter = h;
        vcounter = v;
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) begin
            mem[a] = 8'(a) ^ {1'b0, 7'(a >> 8)};
        end
        mem[0] = 8'hE3;

        tbl[0]  = '{11'd256, 11'd176, 1'b0, 1'b1, 1'b1, 1'b1, 15'd0,     8'hE3};
        tbl[1]  = '{11'd383, 11'd303, 1'b0, 1'b0, 1'b1, 1'b1, 15'd16383, 8'hC0};
        tbl[2]  = '{11'd384, 11'd303, 1'b0, 1'b1, 1'b0, 1'b0, 15'd16383, 8'h25};
        tbl[3]  = '{11'd300, 11'd200, 1'b0, 1'b0, 1'b0, 1'b1, 15'd3116,  8'h20};
        tbl[4]  = '{11'd255, 11'd176, 1'b0, 1'b1, 1'b1, 1'b0, 15'd3116,  8'h25};
        tbl[5]  = '{11'd256, 11'd175, 1'b0, 1'b1, 1'b0, 1'b0, 15'd3116,  8'h25};
        tbl[6]  = '{11'd256, 11'd304, 1'b0, 1'b0, 1'b1, 1'b0, 15'd3116,  8'h25};
        tbl[7]  = '{11'd320, 11'd180, 1'b1, 1'b1, 1'b1, 1'b1, 15'd576,   8'h00};
        tbl[8]  = '{11'd700, 11'd500, 1'b1, 1'b0, 1'b0, 1'b0, 15'd576,   8'h00};
        tbl[9]  = '{11'd383, 11'd176, 1'b0, 1'b1, 1'b1, 1'b1, 15'd127,   8'h7F};
        tbl[10] = '{11'd256, 11'd303, 1'b0, 1'b1, 1'b0, 1'b1, 15'd16256, 8'hBF};

        // Reset state
        #12;
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'd1);
        chk("rst_HS_out", 32'(HS_out), 32'd1);
        chk("rst_VS_out", 32'(VS_out), 32'd1);
        chk("rst_blank_out", 32'(blank_out), 32'd1);
        tick();
        rst = 1'b0;

        // Steady-state vectors: hold each input for the full pipeline depth
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].h, tbl[i].v);
            blank_in = tbl[i].blk;
            HS_in = tbl[i].hs;
            VS_in = tbl[i].vs;
            tick(); tick(); tick();
            chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(tbl[i].rgb));
            chk($sformatf("vec%0d_blank_out", i), 32'(blank_out), 32'(tbl[i].blk));
            chk($sformatf("vec%0d_HS_out", i), 32'(HS_out), 32'(tbl[i].hs));
            chk($sformatf("vec%0d_VS_out", i), 32'(VS_out), 32'(tbl[i].vs));
        end

        // Latency: window entry and sync edges take exactly three cycles
        blank_in = 1'b0; HS_in = 1'b1; VS_in = 1'b1;
        drive(11'd700, 11'd500);
        tick(); tick(); tick();
        drive(11'd256, 11'd176); HS_in = 1'b0; VS_in = 1'b0;
        tick();
        chk("lat_t1_mem_en", 32'(mem_en), 32'd1);
        chk("lat_t1_mem_addr", 32'(mem_addr), 32'd0);
        chk("lat_t1_HS_out", 32'(HS_out), 32'd1);
        tick();
        chk("lat_t2_rgb", 32'(rgb), 32'h25);
        chk("lat_t2_VS_out", 32'(VS_out), 32'd1);
        tick();
        chk("lat_t3_rgb", 32'(rgb), 32'hE3);
        chk("lat_t3_HS_out", 32'(HS_out), 32'd0);
        chk("lat_t3_VS_out", 32'(VS_out), 32'd0);
        drive(11'd384, 11'd176); HS_in = 1'b1;
        tick();
        chk("exit_t1_mem_en", 32'(mem_en), 32'd0);
        chk("exit_t1_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("exit_t2_rgb", 32'(rgb), 32'hE3);
        chk("exit_t2_HS_out", 32'(HS_out), 32'd0);
        tick();
        chk("exit_t3_rgb", 32'(rgb), 32'h25);
        chk("exit_t3_HS_out", 32'(HS_out), 32'd1);

        // Scaled window instance
        drive(11'd65, 11'd113); tick();
        chk("scale_65_113_addr", 32'(mem_addr2), 32'd0);
        chk("scale_65_113_en", 32'(mem_en2), 32'd1);
        drive(11'd66, 11'd114); tick();
        chk("scale_66_114_addr", 32'(mem_addr2), 32'd129);
        drive(11'd300, 11'd200); tick();
        chk("scale_300_200_addr", 32'(mem_addr2), 32'd5750);
        drive(11'd63, 11'd113); tick();
        chk("scale_left_en", 32'(mem_en2), 32'd0);
        drive(11'd320, 11'd113); tick();
        chk("scale_right_en", 32'(mem_en2), 32'd0);

        // Bank swap: a mid-frame pulse waits for vblank start
        drive(11'd0, 11'd100); swap_req = 1'b1; tick();
        chk("swap_early_ack", 32'(swap_ack), 32'd0);
        swap_req = 1'b0;
        drive(11'd10, 11'd200); tick();
        chk("swap_wait_ack", 32'(swap_ack), 32'd0);
        chk("swap_wait_wr_bank", 32'(wr_bank), 32'd1);
        drive(11'd0, 11'd480); tick();
        chk("swap1_ack", 32'(swap_ack), 32'd1);
        chk("swap1_wr_bank", 32'(wr_bank), 32'd0);
        drive(11'd1, 11'd480); tick();
        chk("swap1_ack_drop", 32'(swap_ack), 32'd0);
        drive(11'd0, 11'd480); tick();
        chk("swap1_no_repeat", 32'(swap_ack), 32'd0);
        chk("swap1_bank_held", 32'(wr_bank), 32'd0);
        drive(11'd256, 11'd176); tick();
        chk("bank1_mem_addr", 32'(mem_addr), 32'd16384);
        tick(); tick();
        chk("bank1_rgb", 32'(rgb), 32'h40);

        // Held request: one swap per frame
        swap_req = 1'b1;
        drive(11'd0, 11'd480); tick();
        chk("held_swap2_ack", 32'(swap_ack), 32'd1);
        chk("held_swap2_wr_bank", 32'(wr_bank), 32'd1);
        drive(11'd1, 11'd480); tick();
        chk("held_between_ack", 32'(swap_ack), 32'd0);
        drive(11'd0, 11'd480); tick();
        chk("held_swap3_ack", 32'(swap_ack), 32'd1);
        chk("held_swap3_wr_bank", 32'(wr_bank), 32'd0);
        swap_req = 1'b0;

        // Reset mid-window
        drive(11'd256, 11'd176); HS_in = 1'b0; VS_in = 1'b0; blank_in = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_rgb", 32'(rgb), 32'h40);
        rst = 1'b1;
        #1;
        chk("midrst_rgb", 32'(rgb), 32'd0);
        chk("midrst_HS_out", 32'(HS_out), 32'd1);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_wr_bank", 32'(wr_bank), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_t1_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("post_rst_t2_rgb", 32'(rgb), 32'd0);
        chk("post_rst_t2_blank", 32'(blank_out), 32'd1);
        tick();
        chk("post_rst_t3_rgb", 32'(rgb), 32'hE3);
        chk("post_rst_t3_blank", 32'(blank_out), 32'd0);
        chk("post_rst_t3_HS_out", 32'(HS_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
